// File: rtl/nibble_serial_addsub_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/sub sequencer.
package nibble_serial_addsub_ctrl_pkg;

    localparam int unsigned NibbleW = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_addsub_ctrl_slice.sv
// Combinational 4-bit carry-look-ahead adder slice; b arrives already conditioned for subtract.
module cla_addsub_slice_4b
    import nibble_serial_addsub_ctrl_pkg::*;
(
    input  logic [NibbleW-1:0] a,
    input  logic [NibbleW-1:0] b,
    input  logic               cin,
    output logic [NibbleW-1:0] sum,
    output logic               cout
);

    logic [NibbleW-1:0] g;
    logic [NibbleW-1:0] p;
    logic [NibbleW:0]   c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[NibbleW-1:0];
        cout = c[NibbleW];
    end

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// Multi-cycle WIDTH-bit add/sub: one 4-bit CLA slice iterated LSB nibble first.
module nibble_serial_addsub_ctrl
    import nibble_serial_addsub_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned NIB  = WIDTH / NibbleW;
    localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIB - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q, work_q, work_d;
    logic               sub_q, carry_q;
    logic [IdxW-1:0]    idx_q;
    logic [WIDTH-1:0]   result_q;
    logic               cout_q, overflow_q, zero_q;

    logic [NibbleW-1:0] slice_a, slice_b, slice_sum;
    logic               slice_cout;
    logic               accept, last;

    cla_addsub_slice_4b u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        slice_a = a_q[idx_q*NibbleW +: NibbleW];
        slice_b = b_q[idx_q*NibbleW +: NibbleW] ^ {NibbleW{sub_q}};
        work_d  = work_q;
        work_d[idx_q*NibbleW +: NibbleW] = slice_sum;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            StIdle: begin
                accept = start;
                if (start) state_d = StRun;
            end
            StRun: begin
                last = (idx_q == LastIdx);
                if (last) state_d = StDone;
            end
            StDone: begin
                // Back-to-back: a start here is taken exactly as in idle.
                accept  = start;
                state_d = start ? StRun : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            work_q     <= '0;
            sub_q      <= 1'b0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q     <= a;
                b_q     <= b;
                sub_q   <= sub;
                carry_q <= sub;
                idx_q   <= '0;
                work_q  <= '0;
            end else if (state_q == StRun) begin
                work_q  <= work_d;
                carry_q <= slice_cout;
                if (!last) idx_q <= idx_q + 1'b1;
            end
            if (last) begin
                result_q   <= work_d;
                cout_q     <= slice_cout;
                overflow_q <= (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ sub_q))
                           && (work_d[WIDTH-1] != a_q[WIDTH-1]);
                zero_q     <= (work_d == '0);
            end
        end
    end

    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Randomized and directed bench for nibble_serial_addsub_ctrl against an arithmetic model.
module tb_nibble_serial_addsub_ctrl;

    localparam int unsigned W   = 16;
    localparam int unsigned NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] result;
    logic         cout, overflow, zero;

    int checks = 0;
    int errors = 0;

    nibble_serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: signed/unsigned integer arithmetic on the operands.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                         output logic [W-1:0] res, output logic c, output logic ov,
                         output logic z);
        longint ua, ub, sa, sb, sr;
        logic [63:0] bits;
        ua = longint'(ma);
        ub = longint'(mb);
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        if (ms) begin
            sr = sa - sb;
            c  = (ua >= ub);
        end else begin
            sr = sa + sb;
            c  = (ua + ub) >= (longint'(1) << W);
        end
        ov   = (sr > ((longint'(1) << (W - 1)) - 1)) || (sr < -(longint'(1) << (W - 1)));
        bits = 64'(sr);
        res  = bits[W-1:0];
        z    = (res == '0);
    endtask

    task automatic drive_start(input logic [W-1:0] da, input logic [W-1:0] db,
                               input logic ds);
        start = 1'b1;
        a     = da;
        b     = db;
        sub   = ds;
    endtask

    // Called with start already driven; the next rising edge accepts the op.
    task automatic complete(input logic [W-1:0] ea, input logic [W-1:0] eb, input logic es,
                            input bit mid_start, input bit chain,
                            input logic [W-1:0] na, input logic [W-1:0] nb, input logic ns);
        int cycles, busy_cnt;
        logic [W-1:0] er;
        logic ec, eo, ez;
        model(ea, eb, es, er, ec, eo, ez);
        tick();
        start    = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        sub      = 1'($urandom);
        cycles   = 1;
        busy_cnt = 0;
        while (!done && cycles < 20) begin
            if (busy) busy_cnt++;
            if (mid_start) start = (cycles == 2);
            tick();
            cycles++;
        end
        start = 1'b0;
        check("latency", 32'(cycles), 32'(NIB + 1));
        check("busy_cycles", 32'(busy_cnt), 32'(NIB));
        check("busy_in_done", 32'(busy), 32'(0));
        check("result", 32'(result), 32'(er));
        check("cout", 32'(cout), 32'(ec));
        check("overflow", 32'(overflow), 32'(eo));
        check("zero", 32'(zero), 32'(ez));
        if (chain) drive_start(na, nb, ns);
    endtask

    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic os);
        @(negedge clk);
        drive_start(oa, ob, os);
        complete(oa, ob, os, 1'b0, 1'b0, '0, '0, 1'b0);
        tick();
        check("done_pulse_one_cycle", 32'(done), 32'(0));
    endtask

    initial begin
        int done_seen;
        logic [W-1:0] ra, rb;
        logic rs;

        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_result", 32'(result), 32'(0));
        check("rst_flags", {29'd0, cout, overflow, zero}, 32'(0));
        rst = 1'b0;

        run_op(16'h1234, 16'h0FCD, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0);
        run_op(16'h0005, 16'h0007, 1'b1);
        run_op(16'h8000, 16'h8000, 1'b1);
        run_op(16'h7FFF, 16'h0001, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1);

        // Start during RUN must be ignored.
        @(negedge clk);
        drive_start(16'h1234, 16'h0FCD, 1'b0);
        complete(16'h1234, 16'h0FCD, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        tick();
        check("mid_start_not_queued", {30'd0, busy, done}, 32'(0));

        // Start in the DONE cycle: second op follows back to back.
        @(negedge clk);
        drive_start(16'hA5A5, 16'h5A5B, 1'b0);
        complete(16'hA5A5, 16'h5A5B, 1'b0, 1'b0, 1'b1, 16'h0100, 16'h0200, 1'b1);
        complete(16'h0100, 16'h0200, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        tick();

        // Reset in the middle of RUN: no done, outputs cleared.
        @(negedge clk);
        drive_start(16'h1111, 16'h2222, 1'b0);
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_done", 32'(done), 32'(0));
        check("midrst_result", 32'(result), 32'(0));
        check("midrst_flags", {29'd0, cout, overflow, zero}, 32'(0));
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) done_seen++;
            tick();
        end
        check("midrst_no_done", 32'(done_seen), 32'(0));
        run_op(16'h1234, 16'h0FCD, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom_range(0, 1));
            if (i % 8 == 0) rb = ra;
            if (i % 8 == 1) ra = 16'h8000;
            run_op(ra, rb, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
